// File: rtl/collision_arbiter.sv
// collision_arbiter: per-frame collision accumulator with start-of-frame hit pulses.
// Optional CHAR_HOLDOFF_EN adds a character invulnerability window of HOLDOFF_FRAMES flushes.
module collision_arbiter #(
    parameter int NUM_BUBBLES    = 4,
    parameter int NUM_ARROWS     = 2,
    parameter int X_FRAME_SIZE   = 639,
    parameter int Y_FRAME_SIZE   = 479,
    parameter int HOLDOFF_FRAMES = 60
) (
    input  logic                   clk,
    input  logic                   resetN,
    input  logic                   startOfFrame,
    input  logic [10:0]            pixelX,
    input  logic [10:0]            pixelY,
    input  logic                   charDrawingRequest,
    input  logic [NUM_BUBBLES-1:0] bubbleDrawingRequest,
    input  logic [NUM_ARROWS-1:0]  arrowDrawingRequest,
    output logic [NUM_BUBBLES-1:0] bubbleHitArrow,
    output logic [NUM_ARROWS-1:0]  arrowHitBubble,
    output logic                   bubbleHitChar,
    output logic [NUM_BUBBLES-1:0] bubbleHitWall,
    output logic [NUM_BUBBLES-1:0] bubbleHitFloor,
    output logic [NUM_ARROWS-1:0]  arrowHitCeiling
);
    logic [NUM_ARROWS-1:0][NUM_BUBBLES-1:0] pairHit, pairTerm, winner;
    logic [NUM_BUBBLES-1:0] wallAcc, floorAcc, wallTerm, floorTerm, popMask;
    logic [NUM_ARROWS-1:0]  ceilAcc, ceilTerm, arrowAny;
    logic                   charAcc, charTerm, onEdgeX;

    always_comb begin
        onEdgeX   = pixelX == '0 || pixelX == 11'(X_FRAME_SIZE);
        charTerm  = charDrawingRequest && |bubbleDrawingRequest;
        wallTerm  = bubbleDrawingRequest & {NUM_BUBBLES{onEdgeX}};
        floorTerm = bubbleDrawingRequest & {NUM_BUBBLES{pixelY == 11'(Y_FRAME_SIZE)}};
        ceilTerm  = arrowDrawingRequest & {NUM_ARROWS{pixelY == '0}};
        popMask   = '0;
        // Each arrow pops only its lowest-index overlapping bubble (isolate lowest set bit).
        for (int a = 0; a < NUM_ARROWS; a++) begin
            pairTerm[a] = bubbleDrawingRequest & {NUM_BUBBLES{arrowDrawingRequest[a]}};
            winner[a]   = pairHit[a] & -pairHit[a];
            arrowAny[a] = |pairHit[a];
            popMask     = popMask | winner[a];
        end
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            pairHit         <= '0;
            charAcc         <= 1'b0;
            wallAcc         <= '0;
            floorAcc        <= '0;
            ceilAcc         <= '0;
            bubbleHitArrow  <= '0;
            arrowHitBubble  <= '0;
            bubbleHitWall   <= '0;
            bubbleHitFloor  <= '0;
            arrowHitCeiling <= '0;
        end else begin
            // The start-of-frame pixel already belongs to the new frame, so it seeds the accumulators.
            pairHit         <= startOfFrame ? pairTerm  : pairHit | pairTerm;
            charAcc         <= startOfFrame ? charTerm  : charAcc | charTerm;
            wallAcc         <= startOfFrame ? wallTerm  : wallAcc | wallTerm;
            floorAcc        <= startOfFrame ? floorTerm : floorAcc | floorTerm;
            ceilAcc         <= startOfFrame ? ceilTerm  : ceilAcc | ceilTerm;
            bubbleHitArrow  <= startOfFrame ? popMask   : '0;
            arrowHitBubble  <= startOfFrame ? arrowAny  : '0;
            bubbleHitWall   <= startOfFrame ? wallAcc   : '0;
            bubbleHitFloor  <= startOfFrame ? floorAcc  : '0;
            arrowHitCeiling <= startOfFrame ? ceilAcc   : '0;
        end
    end

`ifdef CHAR_HOLDOFF_EN
    localparam int CW = $clog2(HOLDOFF_FRAMES + 1);
    logic [CW-1:0] holdCnt;

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            holdCnt       <= '0;
            bubbleHitChar <= 1'b0;
        end else begin
            bubbleHitChar <= startOfFrame && charAcc && holdCnt == '0;
            if (startOfFrame)
                holdCnt <= holdCnt != '0 ? holdCnt - CW'(1) : (charAcc ? CW'(HOLDOFF_FRAMES) : '0);
        end
    end
`else
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) bubbleHitChar <= 1'b0;
        else bubbleHitChar <= startOfFrame && charAcc;
    end
`endif
endmodule

// File: tb/tb_collision_arbiter.sv
// tb_collision_arbiter: directed-vector bench for collision_arbiter (honours CHAR_HOLDOFF_EN).
module tb_collision_arbiter;
    logic        clk = 1'b0;
    logic        resetN = 1'b0;
    logic        startOfFrame = 1'b0;
    logic [10:0] pixelX = 11'd300;
    logic [10:0] pixelY = 11'd300;
    logic        charDrawingRequest = 1'b0;
    logic [3:0]  bubbleDrawingRequest = '0;
    logic [1:0]  arrowDrawingRequest = '0;
    logic [3:0]  bubbleHitArrow, bubbleHitWall, bubbleHitFloor;
    logic [1:0]  arrowHitBubble, arrowHitCeiling;
    logic        bubbleHitChar;
    int compared = 0;
    int mismatched = 0;

    collision_arbiter #(.NUM_BUBBLES(4), .NUM_ARROWS(2), .X_FRAME_SIZE(639), .Y_FRAME_SIZE(479),
                        .HOLDOFF_FRAMES(2)) dut (
        .clk(clk), .resetN(resetN), .startOfFrame(startOfFrame), .pixelX(pixelX), .pixelY(pixelY),
        .charDrawingRequest(charDrawingRequest), .bubbleDrawingRequest(bubbleDrawingRequest),
        .arrowDrawingRequest(arrowDrawingRequest), .bubbleHitArrow(bubbleHitArrow),
        .arrowHitBubble(arrowHitBubble), .bubbleHitChar(bubbleHitChar), .bubbleHitWall(bubbleHitWall),
        .bubbleHitFloor(bubbleHitFloor), .arrowHitCeiling(arrowHitCeiling)
    );

    always #5 clk = ~clk;

    task automatic drive(input logic sof, input int x, input int y, input logic c,
                         input logic [3:0] b, input logic [1:0] a);
        @(negedge clk);
        startOfFrame = sof;
        pixelX = 11'(x);
        pixelY = 11'(y);
        charDrawingRequest = c;
        bubbleDrawingRequest = b;
        arrowDrawingRequest = a;
    endtask

    task automatic idle(input logic sof);
        drive(sof, 300, 300, 1'b0, 4'b0000, 2'b00);
    endtask

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chkAll(input string tag, input logic [3:0] bha, input logic [1:0] ahb, input logic chr,
                          input logic [3:0] wall, input logic [3:0] flr, input logic [1:0] ceil);
        chk({tag, ".bubbleHitArrow"}, bubbleHitArrow, bha);
        chk({tag, ".arrowHitBubble"}, {2'b00, arrowHitBubble}, {2'b00, ahb});
        chk({tag, ".bubbleHitChar"}, {3'b000, bubbleHitChar}, {3'b000, chr});
        chk({tag, ".bubbleHitWall"}, bubbleHitWall, wall);
        chk({tag, ".bubbleHitFloor"}, bubbleHitFloor, flr);
        chk({tag, ".arrowHitCeiling"}, {2'b00, arrowHitCeiling}, {2'b00, ceil});
    endtask

    initial begin
        logic [2:0] charExp;
`ifdef CHAR_HOLDOFF_EN
        charExp = 3'b001;
`else
        charExp = 3'b111;
`endif
        idle(1'b0);
        idle(1'b0);
        chkAll("reset", 4'b0000, 2'b00, 1'b0, 4'b0000, 4'b0000, 2'b00);
        @(negedge clk);
        resetN = 1'b1;
        idle(1'b1);
        idle(1'b0);
        chkAll("emptyFrame", 4'b0000, 2'b00, 1'b0, 4'b0000, 4'b0000, 2'b00);

        drive(1'b0, 100, 200, 1'b0, 4'b0100, 2'b01);
        idle(1'b1);
        idle(1'b0);
        chkAll("b2a0", 4'b0100, 2'b01, 1'b0, 4'b0000, 4'b0000, 2'b00);
        idle(1'b0);
        chkAll("b2a0.after", 4'b0000, 2'b00, 1'b0, 4'b0000, 4'b0000, 2'b00);

        drive(1'b0, 50, 50, 1'b0, 4'b1010, 2'b10);
        idle(1'b1);
        idle(1'b0);
        chkAll("a1lowest", 4'b0010, 2'b10, 1'b0, 4'b0000, 4'b0000, 2'b00);

        drive(1'b0, 60, 60, 1'b0, 4'b0010, 2'b11);
        idle(1'b1);
        idle(1'b0);
        chkAll("sameBubble", 4'b0010, 2'b11, 1'b0, 4'b0000, 4'b0000, 2'b00);

        drive(1'b0, 639, 479, 1'b0, 4'b0001, 2'b00);
        drive(1'b0, 100, 0, 1'b0, 4'b0000, 2'b01);
        drive(1'b0, 0, 100, 1'b0, 4'b1000, 2'b00);
        idle(1'b1);
        idle(1'b0);
        chkAll("edges", 4'b0000, 2'b00, 1'b0, 4'b1001, 4'b0001, 2'b01);

        drive(1'b1, 10, 10, 1'b0, 4'b0001, 2'b01);
        idle(1'b0);
        chkAll("sofOverlap.now", 4'b0000, 2'b00, 1'b0, 4'b0000, 4'b0000, 2'b00);
        idle(1'b1);
        idle(1'b0);
        chkAll("sofOverlap.next", 4'b0001, 2'b01, 1'b0, 4'b0000, 4'b0000, 2'b00);

        drive(1'b1, 100, 200, 1'b0, 4'b0100, 2'b01);
        idle(1'b1);
        idle(1'b0);
        chkAll("backToBack", 4'b0100, 2'b01, 1'b0, 4'b0000, 4'b0000, 2'b00);

        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 200, 200, 1'b1, 4'b0001, 2'b00);
            idle(1'b1);
            idle(1'b0);
            chkAll($sformatf("charFrame%0d", i), 4'b0000, 2'b00, charExp[i], 4'b0000, 4'b0000, 2'b00);
        end

        drive(1'b0, 0, 479, 1'b1, 4'b0100, 2'b01);
        idle(1'b0);
        resetN = 1'b0;
        #1;
        chkAll("asyncReset", 4'b0000, 2'b00, 1'b0, 4'b0000, 4'b0000, 2'b00);
        @(negedge clk);
        resetN = 1'b1;
        idle(1'b0);
        idle(1'b1);
        idle(1'b0);
        chkAll("postReset", 4'b0000, 2'b00, 1'b0, 4'b0000, 4'b0000, 2'b00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule

// File: doc/collision_arbiter.md
# collision_arbiter

Parametrised, frame-synchronous collision detector for the game-object layer. It sits between the object drawers and the movement and score logic. Per pixel, it accumulates overlaps between the character, NUM_BUBBLES bubbles and NUM_ARROWS arrows, plus bubble and arrow contacts with the screen frame. At each start of frame it resolves arrow-to-bubble conflicts and issues one-cycle, once-per-frame hit pulses to the consuming objects.

## Interface
Parameters:
- NUM_BUBBLES, 4, bubble channels (1..16)
- NUM_ARROWS, 2, arrow channels (1..4)
- X_FRAME_SIZE, 639, last visible pixel column
- Y_FRAME_SIZE, 479, last visible pixel row
- HOLDOFF_FRAMES, 60, character invulnerability length in frames (only with CHAR_HOLDOFF_EN)

Ports:
- clk  in  1  system clock
- resetN  in  1  asynchronous active-low reset
- startOfFrame  in  1  one-cycle pulse at the first pixel of a frame
- pixelX  in  11  current pixel column
- pixelY  in  11  current pixel row
- charDrawingRequest  in  1  character covers current pixel
- bubbleDrawingRequest  in  NUM_BUBBLES  bit b: bubble b covers current pixel
- arrowDrawingRequest  in  NUM_ARROWS  bit a: arrow a covers current pixel
- bubbleHitArrow  out  NUM_BUBBLES  bubble b popped this frame (pulse)
- arrowHitBubble  out  NUM_ARROWS  arrow a consumed this frame (pulse)
- bubbleHitChar  out  1  character touched by any bubble (pulse)
- bubbleHitWall  out  NUM_BUBBLES  bubble b touched column 0 or X_FRAME_SIZE (pulse)
- bubbleHitFloor  out  NUM_BUBBLES  bubble b touched row Y_FRAME_SIZE (pulse)
- arrowHitCeiling  out  NUM_ARROWS  arrow a touched row 0 (pulse)

## Operation
- Accumulation registers: pairHit[NUM_BUBBLES][NUM_ARROWS], charAcc, wallAcc[], floorAcc[], ceilAcc[]. All are sticky-set during the frame.
- Each cycle with no startOfFrame:
  - pairHit[b][a] |= bubbleReq[b] & arrowReq[a]
  - charAcc |= charReq & |bubbleReq
  - wallAcc[b] |= bubbleReq[b] & (pixelX==0 | pixelX==X_FRAME_SIZE)
  - floorAcc[b] |= bubbleReq[b] & pixelY==Y_FRAME_SIZE
  - ceilAcc[a] |= arrowReq[a] & pixelY==0
- Resolution happens on startOfFrame and uses the accumulated values from the previous frame:
  - For each arrow a, winner = lowest-index b with pairHit[b][a]. arrowHitBubble[a]=1 if a winner exists.
  - bubbleHitArrow[b]=1 if bubble b is the winner for at least one arrow. Two arrows may pop two different bubbles, or the same bubble.
  - bubbleHitChar=charAcc (gated, see Configuration). Wall, floor and ceiling outputs copy their accumulators.
- On the startOfFrame cycle, every accumulator loads that cycle's pixel terms instead of OR-ing. That pixel belongs to the new frame; nothing is lost or double-counted.
- Frames without startOfFrame never flush. Accumulators saturate (sticky) until the next pulse.
- Reset mid-frame: all accumulators, outputs and the holdoff counter clear immediately. The first pulse after reset reports only the hits accumulated since reset deassertion.

## Timing
- All outputs are registered and 0 at reset.
- Every output pulses high for exactly one clk cycle: the cycle after startOfFrame is sampled high. Otherwise outputs are 0.
- Latency from a colliding pixel to its pulse is up to one frame plus 1 cycle.
- Back-to-back startOfFrame pulses (degenerate frame) are legal. The second pulse reports only the single pixel captured by the first.

## Configuration
- CHAR_HOLDOFF_EN defined:
  - A raised bubbleHitChar loads a frame counter with HOLDOFF_FRAMES. The counter decrements on each startOfFrame.
  - While the counter is nonzero, bubbleHitChar is forced to 0 and charAcc is still cleared per frame.
  - The counter reaches 0 after HOLDOFF_FRAMES flushes. The next flush may then report again.
- CHAR_HOLDOFF_EN not defined: no counter exists, and bubbleHitChar reports every frame that contains a character/bubble overlap.

## Test plan
- Bubble 2 and arrow 0 overlap at (100,200) mid-frame, then startOfFrame -> next cycle bubbleHitArrow=4'b0100, arrowHitBubble=2'b01 for 1 cycle, then 0.
- Arrow 1 overlaps bubbles 1 and 3 in one frame -> bubbleHitArrow=4'b0010 only, arrowHitBubble=2'b10.
- Bubble 0 drawn at pixelX=639 and pixelY=479 -> bubbleHitWall[0]=1 and bubbleHitFloor[0]=1 in the same pulse. Arrow 0 at pixelY=0 -> arrowHitCeiling[0]=1.
- Overlap asserted exactly on the startOfFrame cycle -> no pulse on this flush; reported on the following flush.
- Character/bubble overlap every frame for 3 frames:
  - With CHAR_HOLDOFF_EN and HOLDOFF_FRAMES=2: pulse only after frame 1, then none for the next 2 flushes.
  - Without the macro: 3 pulses.
- Overlap accumulated, resetN pulsed low mid-frame, then startOfFrame -> all outputs remain 0.
